pattern_scan_ctrl: RTL and testbench

//  Controller that sequences a serial pattern matcher from a byte stream. Accepts DATA_W-bit words

---
 rtl/psc_pkg.sv | 11 +
 rtl/pattern_scan_ctrl_if.sv | 30 +++
 rtl/pattern_match_core.sv | 49 ++++
 rtl/pattern_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/psc_pkg.sv
// rtl/psc_pkg.sv - shared types and reset constants for pattern_scan_ctrl
package psc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] PAT_RESET_DEF = 4'b1011;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// rtl/pattern_scan_ctrl_if.sv - word stream, config and status bundle of pattern_scan_ctrl
interface pattern_scan_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 16
) ();

  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [CNT_W-1:0]  cfg_thresh;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              det_pulse;
  logic [CNT_W-1:0]  match_cnt;
  logic              irq;
  logic              irq_clr;

  modport master (
    output cfg_we, cfg_pattern, cfg_thresh, in_valid, in_data, irq_clr,
    input  in_ready, busy, det_pulse, match_cnt, irq
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_thresh, in_valid, in_data, irq_clr,
    output in_ready, busy, det_pulse, match_cnt, irq
  );

endinterface

// File: rtl/pattern_match_core.sv
// rtl/pattern_match_core.sv - overlapping serial pattern detector with registered det_pulse
module pattern_match_core #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             clr,
  input  logic [PAT_W-1:0] pattern,
  output logic             det_pulse
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic              det_q, det_d;

  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], bit_in};
    fill_inc   = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    hist_d     = shift_en ? hist_shift : hist_q;
    // clr drops the fill after this cycle's bit has been evaluated
    if (clr) begin
      fill_d = '0;
    end else if (shift_en) begin
      fill_d = fill_inc;
    end else begin
      fill_d = fill_q;
    end
    det_d = shift_en && (fill_inc == FILL_W'(PAT_W)) && (hist_shift == pattern);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
    end
  end

  assign det_pulse = det_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - word serialiser, match counter and irq; PSC_BYTE_ALIGN_EN confines matches to one word
module pattern_scan_ctrl
  import psc_pkg::*;
#(
  parameter int               DATA_W    = 8,
  parameter int               PAT_W     = 4,
  parameter int               CNT_W     = 16,
  parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(PAT_RESET_DEF)
) (
  input logic               clk,
  input logic               reset_n,
  pattern_scan_ctrl_if.slave bus
);

  localparam int              IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [CNT_W-1:0]  thresh_q, thresh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_next;
  logic              irq_q, irq_d;

  logic accept, cfg_fire, align_clr, det, cnt_inc_en, irq_set;

  assign accept   = bus.in_valid && in_ready_q;
  assign cfg_fire = bus.cfg_we && (state_q == IDLE) && !bus.in_valid;

`ifdef PSC_BYTE_ALIGN_EN
  assign align_clr = accept;
`else
  assign align_clr = 1'b0;
`endif

  pattern_match_core #(.PAT_W(PAT_W)) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .shift_en  (state_q == SHIFT),
    .bit_in    (word_q[bit_idx_q]),
    .clr       (cfg_fire || align_clr),
    .pattern   (pattern_q),
    .det_pulse (det)
  );

  assign cnt_next   = cnt_q + 1'b1;
  assign cnt_inc_en = det && (cnt_q != '1);
  assign irq_set    = cnt_inc_en && (cnt_next == thresh_q) && (thresh_q != '0);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    word_d    = word_q;
    pattern_d = pattern_q;
    thresh_d  = thresh_q;
    cnt_d     = cnt_q;
    irq_d     = irq_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SHIFT;
          word_d    = bus.in_data;
          bit_idx_d = IDX_LAST;
        end
      end
      SHIFT: begin
        // last bit goes out this cycle; reload with no bubble if a word is offered
        if (bit_idx_q == '0) begin
          if (accept) begin
            word_d    = bus.in_data;
            bit_idx_d = IDX_LAST;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_idx_d = bit_idx_q - 1'b1;
        end
      end
    endcase

    in_ready_d = (state_d == IDLE) || (bit_idx_d == '0);
    busy_d     = (state_d == SHIFT);

    if (cfg_fire) begin
      pattern_d = bus.cfg_pattern;
      thresh_d  = bus.cfg_thresh;
      cnt_d     = '0;
      irq_d     = 1'b0;
    end else begin
      if (cnt_inc_en) begin
        cnt_d = cnt_next;
      end
      if (irq_set) begin
        irq_d = 1'b1;
      end else if (bus.irq_clr) begin
        irq_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      word_q     <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      pattern_q  <= PAT_RESET;
      thresh_q   <= '0;
      cnt_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      word_q     <= word_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      pattern_q  <= pattern_d;
      thresh_q   <= thresh_d;
      cnt_q      <= cnt_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.det_pulse = det;
  assign bus.match_cnt = cnt_q;
  assign bus.irq       = irq_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - directed and randomized checks of pattern_scan_ctrl against a bit-queue model
module tb_pattern_scan_ctrl;

  localparam int DATA_W  = 8;
  localparam int PAT_W   = 4;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pattern_scan_ctrl_if #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();
  pattern_scan_ctrl_if #(.DATA_W(8), .PAT_W(2), .CNT_W(2)) bus2 ();

  pattern_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W), .PAT_RESET(4'b1011)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  pattern_scan_ctrl #(.DATA_W(8), .PAT_W(2), .CNT_W(2), .PAT_RESET(2'b11)) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int pulses1 = 0;
  int pulses2 = 0;

  always @(posedge clk) begin
    if (bus.det_pulse === 1'b1) pulses1 <= pulses1 + 1;
    if (bus2.det_pulse === 1'b1) pulses2 <= pulses2 + 1;
  end

  // reference model: the bits seen since the last history clear, plus count/irq state
  bit mq[$];
  int m_pat, m_thresh, m_cnt, m_total;
  bit m_irq;

  function automatic bit model_bit(input bit b);
    int v;
    mq.push_back(b);
    if (mq.size() > PAT_W) void'(mq.pop_front());
    if (mq.size() != PAT_W) return 1'b0;
    v = 0;
    foreach (mq[i]) v = (v << 1) | int'(mq[i]);
    return v == m_pat;
  endfunction

  // returns expected det_pulse per cycle, index 0 = cycle of the first shifted bit
  function automatic logic [DATA_W:0] model_word(input logic [DATA_W-1:0] w);
    logic [DATA_W:0] dv;
    dv = '0;
`ifdef PSC_BYTE_ALIGN_EN
    mq.delete();
`endif
    for (int j = 0; j < DATA_W; j++) begin
      if (model_bit(w[DATA_W-1-j])) begin
        dv[j+1] = 1'b1;
        m_total++;
        if (m_cnt < CNT_MAX) begin
          m_cnt++;
          if (m_thresh != 0 && m_cnt == m_thresh) m_irq = 1'b1;
        end
      end
    end
    return dv;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_pat = 4'b1011; m_thresh = 0; m_cnt = 0; m_irq = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] w, output int waited);
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk("push_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", bus.busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic cfg(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] thr);
    wait_idle();
    bus.cfg_we = 1'b1; bus.cfg_pattern = pat; bus.cfg_thresh = thr;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    mq.delete();
    m_pat = int'(pat); m_thresh = int'(thr); m_cnt = 0; m_irq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, w1, p0, k;
    logic [DATA_W:0] dv;
    logic [11:0] obs;

    bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_thresh = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.irq_clr = 0;
    bus2.cfg_we = 0; bus2.cfg_pattern = '0; bus2.cfg_thresh = '0;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.irq_clr = 0;
    model_reset();
    m_total = 0;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_det", bus.det_pulse, 0);
    chk("rst_cnt", bus.match_cnt, 0);
    chk("rst_irq", bus.irq, 0);

    // word B6 with reset pattern 1011: pulses on cycles 4 and 7
    push(8'hB6, w0);
    dv = model_word(8'hB6);
    for (int i = 0; i < 12; i++) begin
      obs[i] = bus.det_pulse;
      @(negedge clk);
    end
    chk("b6_det_model", obs, {3'b000, dv});
    chk("b6_det_cycles", obs, 12'h090);
    chk("b6_cnt", bus.match_cnt, 2);

    // threshold irq with irq_clr colliding with the set
    cfg(4'b1011, 16'd2);
    chk("cfg_cnt_clear", bus.match_cnt, 0);
    push(8'hB6, w0);
    dv = model_word(8'hB6);
    k = 0; p0 = -1;
    for (int i = 0; i <= DATA_W; i++) begin
      if (dv[i]) k++;
      if (dv[i] && k == 2 && p0 < 0) p0 = i;
    end
    for (int i = 0; i < 12; i++) begin
      if (i == p0) chk("irq_before_set", bus.irq, 0);
      if (i == p0 + 1) chk("irq_set_beats_clr", bus.irq, 1);
      bus.irq_clr = (i == p0);
      @(negedge clk);
    end
    bus.irq_clr = 0;
    chk("irq_sticky", bus.irq, 1);
    chk("thr_cnt", bus.match_cnt, m_cnt);
    bus.irq_clr = 1;
    @(negedge clk);
    bus.irq_clr = 0;
    chk("irq_cleared", bus.irq, 0);

    // back-to-back words straddling a match
    cfg(4'b1011, 16'd0);
    push(8'h01, w0);
    dv = model_word(8'h01);
    push(8'h60, w1);
    dv = model_word(8'h60);
    chk("b2b_no_bubble", w1, DATA_W - 1);
    wait_idle();
    chk("b2b_cnt_model", bus.match_cnt, m_cnt);
`ifdef PSC_BYTE_ALIGN_EN
    chk("b2b_cnt", bus.match_cnt, 0);
`else
    chk("b2b_cnt", bus.match_cnt, 1);
`endif

    // cfg_we ignored while shifting, honoured in IDLE
    cfg(4'b1011, 16'd0);
    push(8'hB6, w0);
    dv = model_word(8'hB6);
    bus.cfg_we = 1'b1; bus.cfg_pattern = 4'b0000; bus.cfg_thresh = 16'd5;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    wait_idle();
    chk("cfg_busy_ignored", bus.match_cnt, 2);
    cfg(4'b0110, 16'd0);
    chk("cfg_idle_clear", bus.match_cnt, 0);
    push(8'hB6, w0);
    dv = model_word(8'hB6);
    wait_idle();
    chk("cfg_new_pattern", bus.match_cnt, m_cnt);
    chk("cfg_new_pattern_n", bus.match_cnt, 2);

    // narrow counter saturation on the second instance
    p0 = pulses2;
    bus2.in_valid = 1'b1; bus2.in_data = 8'hFF;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("sat_pulses", pulses2 - p0, 7);
    chk("sat_cnt", bus2.match_cnt, 3);

    // randomized rounds
    for (int r = 0; r < 4; r++) begin
      cfg(4'($urandom_range(0, 15)), 16'($urandom_range(1, 12)));
      p0 = pulses1;
      m_total = 0;
      for (int n = 0; n < 16; n++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        w1 = int'($urandom_range(0, 255));
        push(8'(w1), w0);
        dv = model_word(8'(w1));
      end
      wait_idle();
      chk("rand_cnt", bus.match_cnt, m_cnt);
      chk("rand_pulses", pulses1 - p0, m_total);
      chk("rand_irq", bus.irq, m_irq);
    end

    // async reset in the middle of a word
    push(8'hB6, w0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_det", bus.det_pulse, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_cnt", bus.match_cnt, 0);
    chk("arst_irq", bus.irq, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", bus.in_ready, 1);
    p0 = pulses1;
    repeat (12) @(negedge clk);
    chk("arst_no_pulse", pulses1 - p0, 0);
    chk("arst_cnt_hold", bus.match_cnt, 0);
    push(8'hB6, w0);
    dv = model_word(8'hB6);
    wait_idle();
    chk("arst_pattern", bus.match_cnt, m_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
